// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// opcodes, ALU codes and datapath select codes. Build macro: ILLEGAL_TRAP_EN.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
`ifdef ILLEGAL_TRAP_EN
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
`else
    S_AUIPC    = 4'd13
`endif
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:        return IMM_S;
      OP_BRANCH:       return IMM_B;
      OP_JAL:          return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:         return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU operation decoder: opcode[5], funct3, funct7[5] -> 4-bit ALU code.
// Ports: op5_i, funct3_i, f7b5_i in; alu_ctrl_o out.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic       op5_i,
  input  logic [2:0] funct3_i,
  input  logic       f7b5_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    unique case (funct3_i)
      3'b000: alu_ctrl_o = (op5_i & f7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001: alu_ctrl_o = ALU_SLL;
      3'b010: alu_ctrl_o = ALU_SLT;
      3'b011: alu_ctrl_o = ALU_SLTU;
      3'b100: alu_ctrl_o = ALU_XOR;
      3'b101: alu_ctrl_o = f7b5_i ? ALU_SRA : ALU_SRL;
      3'b110: alu_ctrl_o = ALU_OR;
      3'b111: alu_ctrl_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I Moore control FSM with mem_ready wait/timeout and retire.
// Ports: opcode/funct3/funct7/flags/mem_ready in; datapath controls out. Macro: ILLEGAL_TRAP_EN.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  address_source,
  output logic                  memory_read,
  output logic                  memory_write,
  output logic                  ir_write,
  output logic                  register_write,
  output logic [1:0]            result_source,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            alu_source_a,
  output logic [1:0]            alu_source_b,
  output logic [2:0]            immediate_source,
  output logic                  instr_retired,
  output logic                  bus_error,
  output logic                  illegal_instr
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wait_st;
  logic          timeout;
  logic          br_taken;
  logic [3:0]    dec_alu;
  logic [3:0]    alu4;
  logic          unused_f7;

  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  alu_decoder u_alu_dec (
    .op5_i      (opcode[5]),
    .funct3_i   (funct3),
    .f7b5_i     (funct7[5]),
    .alu_ctrl_o (dec_alu)
  );

  assign wait_st = (state_q == S_FETCH) |
                   (state_q == S_MEMREAD) |
                   (state_q == S_MEMWRITE);

  // Timeout fires on the TIMEOUT_CYCLES-th consecutive cycle without ready.
  assign timeout = TO_EN & wait_st & ~mem_ready & (cnt_q == TO_LAST);

  always_comb begin
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = ~lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = ~ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter clears whenever the state is left or a timeout restarts it.
  always_comb begin
    cnt_d = '0;
    if (TO_EN && wait_st && !mem_ready && !timeout)
      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_REG:    state_d = S_EXECR;
          OP_IMM:    state_d = S_EXECI;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_BRANCH: state_d = S_BRANCH;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:   state_d = S_TRAP;
`else
          default:   state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:
        state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
      S_BRANCH:   state_d = S_FETCH;
      S_LUI, S_AUIPC: state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write         = 1'b0;
    address_source   = 1'b0;
    memory_read      = 1'b0;
    memory_write     = 1'b0;
    ir_write         = 1'b0;
    register_write   = 1'b0;
    result_source    = RES_ALUOUT;
    alu4             = ALU_ADD;
    alu_source_a     = SRCA_PC;
    alu_source_b     = SRCB_RS2;
    immediate_source = 3'd0;
    instr_retired    = 1'b0;
    bus_error        = 1'b0;
    illegal_instr    = 1'b0;
    if (resetn) begin
      immediate_source = imm_sel(opcode);
      case (state_q)
        S_FETCH: begin
          memory_read   = 1'b1;
          alu_source_b  = SRCB_FOUR;
          result_source = RES_ALU;
          ir_write      = mem_ready;
          pc_write      = mem_ready;
          bus_error     = timeout;
        end
        S_DECODE: begin
          alu_source_a = SRCA_OLDPC;
          alu_source_b = SRCB_IMM;
        end
        S_MEMADR: begin
          alu_source_a = SRCA_RS1;
          alu_source_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          address_source = 1'b1;
          memory_read    = 1'b1;
          bus_error      = timeout;
        end
        S_MEMWB: begin
          result_source  = RES_MEM;
          register_write = 1'b1;
          instr_retired  = 1'b1;
        end
        S_MEMWRITE: begin
          address_source = 1'b1;
          memory_write   = 1'b1;
          instr_retired  = mem_ready;
          bus_error      = timeout;
        end
        S_EXECR: begin
          alu_source_a = SRCA_RS1;
          alu_source_b = SRCB_RS2;
          alu4         = dec_alu;
        end
        S_EXECI: begin
          alu_source_a = SRCA_RS1;
          alu_source_b = SRCB_IMM;
          alu4         = dec_alu;
        end
        S_ALUWB: begin
          register_write = 1'b1;
          instr_retired  = 1'b1;
        end
        S_JAL: begin
          alu_source_a = SRCA_OLDPC;
          alu_source_b = SRCB_FOUR;
          pc_write     = 1'b1;
        end
        S_JALR: begin
          alu_source_a = SRCA_RS1;
          alu_source_b = SRCB_IMM;
        end
        S_BRANCH: begin
          alu_source_a  = SRCA_RS1;
          alu_source_b  = SRCB_RS2;
          alu4          = ALU_SUB;
          pc_write      = br_taken;
          instr_retired = 1'b1;
        end
        S_LUI: begin
          alu_source_a = SRCA_ZERO;
          alu_source_b = SRCB_IMM;
        end
        S_AUIPC: begin
          alu_source_a = SRCA_OLDPC;
          alu_source_b = SRCB_IMM;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: begin
          immediate_source = 3'd0;
          illegal_instr    = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign alu_control = ALU_CTRL_W'(alu4);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven bench for mc_control_fsm (TIMEOUT_CYCLES=4).
// Honours ILLEGAL_TRAP_EN when defined for the build.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rw;
    logic [1:0] res;
    logic [3:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] imm;
    logic       ret;
    logic       berr;
    logic       ill;
  } outs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    logic       lt;
    logic       ltu;
    logic       mr;
    outs_t      exp;
  } vec_t;

  logic       clock, resetn;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       zero, lt, ltu, mem_ready;
  logic       pc_write, address_source, memory_read, memory_write;
  logic       ir_write, register_write;
  logic [1:0] result_source, alu_source_a, alu_source_b;
  logic [3:0] alu_control;
  logic [2:0] immediate_source;
  logic       instr_retired, bus_error, illegal_instr;

  int total = 0;
  int bad   = 0;

  vec_t tbl[$];
  logic [6:0] c_op, c_f7;
  logic [2:0] c_f3;
  logic       c_z, c_lt, c_ltu;

  mc_control_fsm #(
    .ALU_CTRL_W     (4),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock            (clock),
    .resetn           (resetn),
    .opcode           (opcode),
    .funct3           (funct3),
    .funct7           (funct7),
    .zero             (zero),
    .lt               (lt),
    .ltu              (ltu),
    .mem_ready        (mem_ready),
    .pc_write         (pc_write),
    .address_source   (address_source),
    .memory_read      (memory_read),
    .memory_write     (memory_write),
    .ir_write         (ir_write),
    .register_write   (register_write),
    .result_source    (result_source),
    .alu_control      (alu_control),
    .alu_source_a     (alu_source_a),
    .alu_source_b     (alu_source_b),
    .immediate_source (immediate_source),
    .instr_retired    (instr_retired),
    .bus_error        (bus_error),
    .illegal_instr    (illegal_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic outs_t o(int pcw, int adr, int mrd, int mwr,
                              int irw, int rw, int res, int alu,
                              int a, int b, int imm, int ret,
                              int berr, int ill);
    outs_t r;
    r.pcw  = pcw[0];
    r.adr  = adr[0];
    r.mrd  = mrd[0];
    r.mwr  = mwr[0];
    r.irw  = irw[0];
    r.rw   = rw[0];
    r.res  = res[1:0];
    r.alu  = alu[3:0];
    r.a    = a[1:0];
    r.b    = b[1:0];
    r.imm  = imm[2:0];
    r.ret  = ret[0];
    r.berr = berr[0];
    r.ill  = ill[0];
    return r;
  endfunction

  function automatic outs_t fr(int imm);
    return o(1, 0, 1, 0, 1, 0, 2, 0, 0, 2, imm, 0, 0, 0);
  endfunction
  function automatic outs_t fw(int imm, int berr);
    return o(0, 0, 1, 0, 0, 0, 2, 0, 0, 2, imm, 0, berr, 0);
  endfunction
  function automatic outs_t dc(int imm);
    return o(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, imm, 0, 0, 0);
  endfunction
  function automatic outs_t wb(int imm);
    return o(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, imm, 1, 0, 0);
  endfunction
  function automatic outs_t ex(int alu, int a, int b, int imm);
    return o(0, 0, 0, 0, 0, 0, 0, alu, a, b, imm, 0, 0, 0);
  endfunction

  function automatic void ctx(logic [6:0] op, logic [2:0] f3,
                              logic [6:0] f7, logic z,
                              logic l, logic lu);
    c_op = op; c_f3 = f3; c_f7 = f7;
    c_z = z; c_lt = l; c_ltu = lu;
  endfunction

  function automatic void row(string n, logic mr, outs_t e);
    vec_t v;
    v.name = n; v.op = c_op; v.f3 = c_f3; v.f7 = c_f7;
    v.z = c_z; v.lt = c_lt; v.ltu = c_ltu; v.mr = mr; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic outs_t act();
    outs_t r;
    r = '{pc_write, address_source, memory_read, memory_write,
          ir_write, register_write, result_source, alu_control,
          alu_source_a, alu_source_b, immediate_source,
          instr_retired, bus_error, illegal_instr};
    return r;
  endfunction

  task automatic check(string n, outs_t e);
    outs_t g;
    g = act();
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, g, e);
    end
  endtask

  task automatic cyc(vec_t v);
    opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    zero = v.z; lt = v.lt; ltu = v.ltu; mem_ready = v.mr;
    #2;
    check(v.name, v.exp);
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;
    resetn = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;

    // addi
    ctx(7'b0010011, 3'b000, 7'h00, 0, 0, 0);
    row("addi_fetch", 1, fr(0));
    row("addi_dec",   1, dc(0));
    row("addi_exec",  1, ex(0, 2, 1, 0));
    row("addi_wb",    1, wb(0));
    // sub (R)
    ctx(7'b0110011, 3'b000, 7'h20, 0, 0, 0);
    row("sub_fetch",  1, fr(0));
    row("sub_dec",    0, dc(0));
    row("sub_exec",   0, ex(1, 2, 0, 0));
    row("sub_wb",     0, wb(0));
    // addi with funct7[5]=1 stays add
    ctx(7'b0010011, 3'b000, 7'h20, 0, 0, 0);
    row("addi7_fetch", 1, fr(0));
    row("addi7_dec",   1, dc(0));
    row("addi7_exec",  1, ex(0, 2, 1, 0));
    row("addi7_wb",    1, wb(0));
    // srai
    ctx(7'b0010011, 3'b101, 7'h20, 0, 0, 0);
    row("srai_fetch", 1, fr(0));
    row("srai_dec",   1, dc(0));
    row("srai_exec",  1, ex(9, 2, 1, 0));
    row("srai_wb",    1, wb(0));
    // srl / sltu / or (R)
    ctx(7'b0110011, 3'b101, 7'h00, 0, 0, 0);
    row("srl_fetch", 1, fr(0));
    row("srl_dec",   1, dc(0));
    row("srl_exec",  1, ex(8, 2, 0, 0));
    row("srl_wb",    1, wb(0));
    ctx(7'b0110011, 3'b011, 7'h00, 0, 0, 0);
    row("sltu_fetch", 1, fr(0));
    row("sltu_dec",   1, dc(0));
    row("sltu_exec",  1, ex(6, 2, 0, 0));
    row("sltu_wb",    1, wb(0));
    // lw, 3 wait cycles in MEMREAD (4th cycle ready meets count=3)
    ctx(7'b0000011, 3'b010, 7'h00, 0, 0, 0);
    row("lw_fetch",  1, fr(0));
    row("lw_dec",    1, dc(0));
    row("lw_adr",    1, ex(0, 2, 1, 0));
    row("lw_wait0",  0, o(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    row("lw_wait1",  0, o(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    row("lw_wait2",  0, o(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    row("lw_rdy",    1, o(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    row("lw_memwb",  0, o(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    // bne taken / not taken
    ctx(7'b1100011, 3'b001, 7'h00, 0, 0, 0);
    row("bne_t_fetch", 1, fr(2));
    row("bne_t_dec",   1, dc(2));
    row("bne_t_br",    1, o(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 1, 0, 0));
    ctx(7'b1100011, 3'b001, 7'h00, 1, 0, 0);
    row("bne_n_fetch", 1, fr(2));
    row("bne_n_dec",   1, dc(2));
    row("bne_n_br",    1, o(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 1, 0, 0));
    // bgeu with ltu=0 taken, funct3 010 never
    ctx(7'b1100011, 3'b111, 7'h00, 0, 1, 0);
    row("bgeu_fetch", 1, fr(2));
    row("bgeu_dec",   1, dc(2));
    row("bgeu_br",    1, o(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 1, 0, 0));
    ctx(7'b1100011, 3'b010, 7'h00, 1, 1, 1);
    row("b010_fetch", 1, fr(2));
    row("b010_dec",   1, dc(2));
    row("b010_br",    1, o(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 1, 0, 0));
    // jal
    ctx(7'b1101111, 3'b000, 7'h00, 0, 0, 0);
    row("jal_fetch", 1, fr(3));
    row("jal_dec",   1, dc(3));
    row("jal_jal",   1, o(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0));
    row("jal_wb",    1, wb(3));
    // jalr
    ctx(7'b1100111, 3'b000, 7'h00, 0, 0, 0);
    row("jalr_fetch", 1, fr(0));
    row("jalr_dec",   1, dc(0));
    row("jalr_tgt",   1, ex(0, 2, 1, 0));
    row("jalr_jal",   1, o(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    row("jalr_wb",    1, wb(0));
    // lui / auipc
    ctx(7'b0110111, 3'b000, 7'h00, 0, 0, 0);
    row("lui_fetch", 1, fr(4));
    row("lui_dec",   1, dc(4));
    row("lui_ex",    1, ex(0, 3, 1, 4));
    row("lui_wb",    1, wb(4));
    ctx(7'b0010111, 3'b000, 7'h00, 0, 0, 0);
    row("auipc_fetch", 1, fr(4));
    row("auipc_dec",   1, dc(4));
    row("auipc_ex",    1, ex(0, 1, 1, 4));
    row("auipc_wb",    1, wb(4));
    // sw completing immediately
    ctx(7'b0100011, 3'b010, 7'h00, 0, 0, 0);
    row("sw_fetch", 1, fr(1));
    row("sw_dec",   1, dc(1));
    row("sw_adr",   1, ex(0, 2, 1, 1));
    row("sw_write", 1, o(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    // sw timing out: 4th idle cycle raises bus_error, no retire
    row("swt_fetch", 1, fr(1));
    row("swt_dec",   1, dc(1));
    row("swt_adr",   1, ex(0, 2, 1, 1));
    row("swt_w0",    0, o(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    row("swt_w1",    0, o(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    row("swt_w2",    0, o(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    row("swt_berr",  0, o(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    // fetch timeout then retried fetch
    ctx(7'b0010011, 3'b100, 7'h00, 0, 0, 0);
    row("ft_w0",    0, fw(0, 0));
    row("ft_w1",    0, fw(0, 0));
    row("ft_w2",    0, fw(0, 0));
    row("ft_berr",  0, fw(0, 1));
    row("ft_w0b",   0, fw(0, 0));
    row("ft_fetch", 1, fr(0));
    row("xori_dec", 1, dc(0));
    row("xori_ex",  1, ex(4, 2, 1, 0));
    row("xori_wb",  1, wb(0));
    // unknown opcode
    ctx(7'b1111111, 3'b000, 7'h00, 0, 0, 0);
    row("ill_fetch", 1, fr(0));
    row("ill_dec",   1, dc(0));
`ifdef ILLEGAL_TRAP_EN
    row("trap0", 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    row("trap1", 1, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    row("trap2", 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`else
    row("ill_refetch", 1, fr(0));
`endif

    // reset state
    @(posedge clock);
    #1;
    check("reset_hold", '0);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    foreach (tbl[i]) cyc(tbl[i]);

    // reset (also leaves TRAP), then abandon an addi in ALUWB
    resetn = 1'b0;
    #2;
    check("rst_pulse", '0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(tbl[i]);
    v = tbl[3];
    opcode = v.op; funct3 = v.f3; funct7 = v.f7; mem_ready = 1'b1;
    #2;
    check("aluwb_pre", wb(0));
    resetn = 1'b0;
    #1;
    check("aluwb_rst", '0);
    @(posedge clock);
    #1;
    check("rst_held", '0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    #1;
    check("rst_refetch", fr(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised successor to the multicycle RV32I control unit. It decodes opcode, funct3 and funct7 into datapath controls through a Moore FSM, one state per cycle. New relative to the previous unit:
- full RV32I branch and ALU set, plus JALR, LUI and AUIPC;
- memory wait-state handshake (mem_ready) with a timeout counter;
- retire pulse.

It sits between the instruction register/ALU flags and the shared multicycle datapath.

Parameters:
ALU_CTRL_W, 4, width of alu_control (must be >= 4)
TIMEOUT_CYCLES, 255, max cycles waiting on mem_ready before bus_error; 0 disables the timeout

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  synchronous, active-low reset
opcode  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7  in  7  instr[31:25]
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2
ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  PC load enable
address_source  out  1  0=PC, 1=ALUOut
memory_read  out  1  read request
memory_write  out  1  write request
ir_write  out  1  IR/oldPC load
register_write  out  1  regfile write enable
result_source  out  2  00=ALUOut, 01=mem data, 10=ALU result
alu_control  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
alu_source_a  out  2  00=PC, 01=oldPC, 10=rs1, 11=zero
alu_source_b  out  2  00=rs2, 01=imm, 10=const 4
immediate_source  out  3  0 I, 1 S, 2 B, 3 J, 4 U
instr_retired  out  1  one-cycle pulse at instruction completion
bus_error  out  1  one-cycle pulse on timeout
illegal_instr  out  1  see Optional Feature

Behaviour:
- Reset: the single clock is `clock`; reset is `resetn`, synchronous and active-low. With resetn=0 at a rising edge, state<=FETCH and the wait counter is cleared. While resetn is low, every output is 0.
- Output defaults: every output is 0 unless listed for the current state. Outputs are combinational from state, with these exceptions:
  - pc_write and ir_write also depend on mem_ready and the flags;
  - immediate_source is decoded from opcode in every state.
- FETCH(0): memory_read=1, a=PC, b=4, add, result_source=10.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Else stay in FETCH.
- DECODE(1): a=oldPC, b=imm, add (ALUOut <= branch/JAL target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 1100011 -> BRANCH
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> FETCH (no retire)
- MEMADR(2): a=rs1, b=imm, add. Next: load -> MEMREAD, store -> MEMWRITE.
- MEMREAD(3): address_source=1, memory_read=1. Wait for mem_ready, then -> MEMWB.
- MEMWB(4): result_source=01, register_write=1, retire, -> FETCH.
- MEMWRITE(5): address_source=1, memory_write=1. When mem_ready: retire, -> FETCH.
- EXECR(6): a=rs1, b=rs2, alu_control from the ALU decoder, -> ALUWB.
- EXECI(8): a=rs1, b=imm, alu_control from the ALU decoder, -> ALUWB.
- ALU decoder (funct3):
  - 000: sub iff opcode[5]&funct7[5], else add
  - 001: sll; 010: slt; 011: sltu; 100: xor
  - 101: sra iff funct7[5], else srl
  - 110: or; 111: and
- ALUWB(7): result_source=00, register_write=1, retire, -> FETCH.
- JAL(9): a=oldPC, b=4, add, result_source=00, pc_write=1, -> ALUWB.
- JALR(11): a=rs1, b=imm, add (ALUOut <= target; the datapath clears bit 0), -> JAL.
- BRANCH(10): a=rs1, b=rs2, sub, result_source=00, retire, -> FETCH.
  - pc_write taken condition by funct3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 never.
- LUI(12): a=zero, b=imm (U), add, -> ALUWB.
- AUIPC(13): a=oldPC, b=imm (U), add, -> ALUWB.
- Wait counter (FETCH, MEMREAD, MEMWRITE only):
  - Clears on entry to any of these states and increments each cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES without mem_ready: bus_error=1 for that cycle, next state FETCH, no retire, no writeback.
  - A timeout in FETCH retries the fetch.
  - If mem_ready and timeout coincide, mem_ready wins.
- Reset mid-instruction: the instruction is abandoned and no retire is issued.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an unrecognised opcode in DECODE goes to TRAP(14).
  - TRAP asserts illegal_instr=1 with all other outputs 0.
  - TRAP persists until reset.
- Undefined: TRAP state is absent, illegal_instr is tied to 0, and an unknown opcode returns to FETCH.

Decomposition:
- Package mc_ctrl_pkg: state encodings, opcode constants, ALU code constants, src-A/src-B/result/immediate select codes.
- One sub-module, alu_decoder: combinational map of opcode[5], funct3, funct7[5] to alu_control.

Test Plan:
- addi (opcode 0010011, funct3 000), mem_ready=1 in fetch -> FETCH, DECODE, EXECI, ALUWB.
  - alu_control=0 in EXECI; register_write=1 and instr_retired=1 in ALUWB; 4 cycles total.
- lw with mem_ready held low 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles, then MEMWB with result_source=01.
- bne (funct3 001): zero=0 -> pc_write=1 in BRANCH; zero=1 -> pc_write=0; both then go to FETCH.
- TIMEOUT_CYCLES=4, mem_ready=0 in MEMWRITE -> bus_error pulses once, next state FETCH, instr_retired stays 0.
- Opcode 1111111 -> with ILLEGAL_TRAP_EN: TRAP, illegal_instr=1 until resetn=0; without: back to FETCH.
- resetn=0 during ALUWB -> next cycle state FETCH, all outputs 0 while reset is held.
